// File: rtl/pic_priority_resolver.sv
// -----------------------------------------------------------------------------
// pic_priority_resolver
//
// Interrupt request / priority / in-service stage of the 8259-style PIC core.
// Synchronizes the IR pins into the IRR, applies the mask, and resolves the
// winning level against the ISR in fully nested mode. It drives INT, runs the
// two-pulse INTA handshake, produces the interrupt vector, and handles AEOI
// and commanded (specific / non-specific) EOI.
//
// Optional feature macro: PIC_ROTATE_EN
//   defined   : automatic rotation. An AEOI clear or non-specific EOI makes
//               the cleared level lowest priority.
//   undefined : fixed priority, IR0 highest, IR7 lowest.
//
// Ports
//   CLK           in   1  system clock, rising edge
//   RST_N         in   1  asynchronous active-low reset
//   IR            in   8  raw interrupt request pins (asynchronous)
//   IMR           in   8  mask register, 1 masks the level
//   ICW2          in   8  vector base, bits [7:3] used
//   LTIM          in   1  1 = level-triggered, 0 = edge-triggered
//   AEOI          in   1  automatic EOI at the second INTA
//   INTA          in   1  active-high acknowledge, synchronous to CLK
//   EOI_STB       in   1  one-cycle EOI command strobe
//   EOI_SPECIFIC  in   1  1 = specific EOI at EOI_LEVEL
//   EOI_LEVEL     in   3  level for a specific EOI
//   INT           out  1  interrupt request to the CPU
//   IRR_OUT       out  8  current IRR
//   ISR           out  8  in-service register
//   INT_LEVEL     out  3  level frozen at the first INTA
//   VECTOR        out  8  {ICW2[7:3], INT_LEVEL}
//   VEC_VALID     out  1  one-cycle pulse while VECTOR is freshly valid
//   SPURIOUS      out  1  first INTA found no eligible request
//
// State table
//   state | meaning
//   IDLE  | no eligible request, INT low
//   REQ   | eligible request pending, INT high, waiting for first INTA
//   ACK1  | first INTA taken, level frozen, waiting for second INTA
// -----------------------------------------------------------------------------
module pic_priority_resolver (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] IR,
  input  logic [7:0] IMR,
  input  logic [7:0] ICW2,
  input  logic       LTIM,
  input  logic       AEOI,
  input  logic       INTA,
  input  logic       EOI_STB,
  input  logic       EOI_SPECIFIC,
  input  logic [2:0] EOI_LEVEL,
  output logic       INT,
  output logic [7:0] IRR_OUT,
  output logic [7:0] ISR,
  output logic [2:0] INT_LEVEL,
  output logic [7:0] VECTOR,
  output logic       VEC_VALID,
  output logic       SPURIOUS
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK1 = 2'd2;

  // Rotate right so that bit 0 of the result is level 'sh'.
  function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] sh);
    logic [15:0] d;
    d = {v, v} >> sh;
    return d[7:0];
  endfunction

  // Index of the lowest set bit (7 when none set; callers qualify with |v).
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [1:0] state, state_nxt;
  logic [7:0] ir_s1, ir_s2, ir_prev;
  logic [7:0] irr, irr_nxt;
  logic [7:0] isr_nxt;
  logic       inta_d;
  logic [2:0] ptr;

  logic [7:0] ir_edge;
  logic       inta_rise, first_ack, second_ack, aeoi_clr;
  logic [2:0] base;
  logic [7:0] rot_req, rot_isr, rot_elig, prio_mask;
  logic [2:0] isr_rank, isr_top, win_level;
  logic       isr_any, elig_any;
  logic [7:0] isr_clr, isr_set, ack_clr;
  logic [2:0] ptr_nxt;

  assign ir_edge   = ir_s2 & ~ir_prev;
  assign inta_rise = INTA & ~inta_d;
  assign first_ack  = inta_rise && (state != ST_ACK1);
  assign second_ack = inta_rise && (state == ST_ACK1);
  assign aeoi_clr   = second_ack && AEOI && !SPURIOUS;

  // Work in "priority space": after rotating by ptr+1, bit 0 is the
  // highest-priority level, so plain lowest-bit-first search applies.
  assign base     = ptr + 3'd1;
  assign rot_req  = rot_right(irr & ~IMR, base);
  assign rot_isr  = rot_right(ISR, base);
  assign isr_any  = |ISR;
  assign isr_rank = first_set(rot_isr);
  assign isr_top  = isr_rank + base;
  // Only levels strictly above the highest in-service level are eligible.
  assign prio_mask = isr_any ? ((8'd1 << isr_rank) - 8'd1) : 8'hFF;
  assign rot_elig  = rot_req & prio_mask;
  assign elig_any  = |rot_elig;
  assign win_level = first_set(rot_elig) + base;

  always_comb begin
    isr_clr = 8'h00;
    isr_set = 8'h00;
    ack_clr = 8'h00;
    ptr_nxt = ptr;
    if (aeoi_clr) isr_clr[INT_LEVEL] = 1'b1;
    if (EOI_STB) begin
      if (EOI_SPECIFIC) begin
        isr_clr[EOI_LEVEL] = 1'b1;
      end else if (isr_any) begin
        isr_clr[isr_top] = 1'b1;
        ptr_nxt = isr_top;
      end
    end
    // The level just serviced by AEOI takes the lowest-priority slot.
    if (aeoi_clr) ptr_nxt = INT_LEVEL;
    if (first_ack && elig_any) begin
      isr_set[win_level] = 1'b1;
      ack_clr[win_level] = 1'b1;
    end
    isr_nxt = (ISR & ~isr_clr) | isr_set;
    // A new edge in the acknowledge cycle wins over the clear.
    if (LTIM) irr_nxt = ir_s2;
    else      irr_nxt = (irr & ~ack_clr) | ir_edge;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (first_ack)     state_nxt = ST_ACK1;
        else if (elig_any) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (first_ack)      state_nxt = ST_ACK1;
        else if (!elig_any) state_nxt = ST_IDLE;
      end
      ST_ACK1: begin
        if (second_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      ir_s1     <= 8'h00;
      ir_s2     <= 8'h00;
      ir_prev   <= 8'h00;
      irr       <= 8'h00;
      inta_d    <= 1'b0;
      ISR       <= 8'h00;
      INT_LEVEL <= 3'd0;
      VECTOR    <= 8'h00;
      VEC_VALID <= 1'b0;
      SPURIOUS  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ir_s1     <= IR;
      ir_s2     <= ir_s1;
      ir_prev   <= ir_s2;
      irr       <= irr_nxt;
      inta_d    <= INTA;
      ISR       <= isr_nxt;
      VEC_VALID <= second_ack;
      if (first_ack) begin
        INT_LEVEL <= elig_any ? win_level : 3'd7;
        SPURIOUS  <= !elig_any;
      end
      if (second_ack) VECTOR <= {ICW2[7:3], INT_LEVEL};
    end
  end

`ifdef PIC_ROTATE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr <= 3'd7;
    else        ptr <= ptr_nxt;
  end
`else
  assign ptr = 3'd7;
  logic unused_ptr_nxt;
  assign unused_ptr_nxt = ^ptr_nxt;
`endif

  assign INT     = (state == ST_REQ);
  assign IRR_OUT = irr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
module tb_pic_priority_resolver;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IR, IMR, ICW2;
  logic       LTIM, AEOI, INTA, EOI_STB, EOI_SPECIFIC;
  logic [2:0] EOI_LEVEL;
  logic       INT;
  logic [7:0] IRR_OUT, ISR, VECTOR;
  logic [2:0] INT_LEVEL;
  logic       VEC_VALID, SPURIOUS;

  pic_priority_resolver dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .IMR(IMR), .ICW2(ICW2), .LTIM(LTIM),
    .AEOI(AEOI), .INTA(INTA), .EOI_STB(EOI_STB), .EOI_SPECIFIC(EOI_SPECIFIC),
    .EOI_LEVEL(EOI_LEVEL), .INT(INT), .IRR_OUT(IRR_OUT), .ISR(ISR),
    .INT_LEVEL(INT_LEVEL), .VECTOR(VECTOR), .VEC_VALID(VEC_VALID),
    .SPURIOUS(SPURIOUS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] vec;
    logic [2:0] lvl;
    logic       spur;
    logic [7:0] isr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_vec    = 0;
  int   n_push   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic ir_pulse(input logic [7:0] m);
    IR = IR | m;
    tick(2);
    IR = IR & ~m;
    tick(2);
  endtask

  task automatic inta_pulse();
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    EOI_STB = 1'b1;
    EOI_SPECIFIC = spec;
    EOI_LEVEL = lvl;
    tick();
    EOI_STB = 1'b0;
    EOI_SPECIFIC = 1'b0;
  endtask

  task automatic push(input logic [7:0] v, input logic [2:0] l, input logic s, input logic [7:0] i);
    exp_t e;
    e.vec = v; e.lvl = l; e.spur = s; e.isr = i;
    sb_q.push_back(e);
    n_push++;
  endtask

  // Scoreboard side: every VEC_VALID cycle must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (VEC_VALID) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        chk("vec_unexpected", VEC_VALID, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("vector", VECTOR, e.vec);
        chk("vec_level", INT_LEVEL, e.lvl);
        chk("vec_spurious", SPURIOUS, e.spur);
        chk("vec_isr", ISR, e.isr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] w1, w2;
    RST_N = 1'b0; IR = 8'h00; IMR = 8'h00; ICW2 = 8'h40; LTIM = 1'b0;
    AEOI = 1'b0; INTA = 1'b0; EOI_STB = 1'b0; EOI_SPECIFIC = 1'b0; EOI_LEVEL = 3'd0;
    tick(3);
    chk("rst_int", INT, 0);
    chk("rst_irr", IRR_OUT, 0);
    chk("rst_isr", ISR, 0);
    chk("rst_level", INT_LEVEL, 0);
    chk("rst_vector", VECTOR, 0);
    chk("rst_vvalid", VEC_VALID, 0);
    chk("rst_spur", SPURIOUS, 0);
    RST_N = 1'b1;
    tick(2);

    // Basic edge-mode service of IR3, first INTA held high for 3 cycles.
    IR = 8'h08;
    tick(3);
    chk("t1_irr_lat3", IRR_OUT, 8'h08);
    chk("t1_int_lat3", INT, 0);
    tick();
    chk("t1_int_lat4", INT, 1);
    IR = 8'h00;
    tick(2);
    INTA = 1'b1;
    tick(3);
    chk("t1_isr", ISR, 8'h08);
    chk("t1_irr_clr", IRR_OUT, 8'h00);
    chk("t1_int_off", INT, 0);
    chk("t1_level", INT_LEVEL, 3);
    chk("t1_held_inta", VEC_VALID, 0);
    INTA = 1'b0;
    tick();
    push(8'h43, 3, 0, 8'h08);
    INTA = 1'b1;
    tick();
    chk("t1_vvalid", VEC_VALID, 1);
    INTA = 1'b0;
    tick();
    chk("t1_vvalid_1cyc", VEC_VALID, 0);

    // Nesting under ISR = 0x08.
    ir_pulse(8'h20);
    chk("t2_irr5", IRR_OUT, 8'h20);
    chk("t2_int_blocked", INT, 0);
    ir_pulse(8'h02);
    chk("t2_int_ir1", INT, 1);
    inta_pulse();
    chk("t2_isr_nest", ISR, 8'h0A);
    chk("t2_level1", INT_LEVEL, 1);
    push(8'h41, 1, 0, 8'h0A);
    inta_pulse();
    tick();
    chk("t2_int_still_blocked", INT, 0);
    eoi(0, 0);
    chk("t2_eoi1", ISR, 8'h08);
    tick();
    chk("t2_int_after_eoi1", INT, 0);
    eoi(0, 0);
    chk("t2_eoi2", ISR, 8'h00);
    tick();
    chk("t2_int_ir5", INT, 1);
    inta_pulse();
    chk("t2_isr5", ISR, 8'h20);
    push(8'h45, 5, 0, 8'h20);
    inta_pulse();
    eoi(1, 5);
    chk("t2_spec_eoi", ISR, 8'h00);
    eoi(0, 0);
    chk("t2_eoi_empty", ISR, 8'h00);

    // Masking.
    IMR = 8'h01;
    IR = 8'h01;
    tick(4);
    chk("t3_irr_masked", IRR_OUT, 8'h01);
    chk("t3_int_masked", INT, 0);
    IMR = 8'h00;
    tick();
    chk("t3_int_unmask", INT, 1);
    inta_pulse();
    chk("t3_isr0", ISR, 8'h01);
    push(8'h40, 0, 0, 8'h01);
    inta_pulse();
    IR = 8'h00;
    eoi(1, 0);
    chk("t3_isr_clr", ISR, 8'h00);

    // Spurious: level mode, IR2 drops before INTA.
    LTIM = 1'b1;
    IR = 8'h04;
    tick(4);
    chk("t4_irr_level", IRR_OUT, 8'h04);
    chk("t4_int_level", INT, 1);
    IR = 8'h00;
    tick(4);
    chk("t4_irr_drop", IRR_OUT, 8'h00);
    chk("t4_int_drop", INT, 0);
    inta_pulse();
    chk("t4_level7", INT_LEVEL, 7);
    chk("t4_spur", SPURIOUS, 1);
    chk("t4_isr", ISR, 8'h00);
    push(8'h47, 7, 1, 8'h00);
    inta_pulse();
    LTIM = 1'b0;

    // Reset between the two INTA pulses.
    ICW2 = 8'hAF;
    ir_pulse(8'h10);
    inta_pulse();
    chk("t6_isr_pre", ISR, 8'h10);
    RST_N = 1'b0;
    #1;
    chk("t6_int", INT, 0);
    chk("t6_irr", IRR_OUT, 0);
    chk("t6_isr", ISR, 0);
    chk("t6_level", INT_LEVEL, 0);
    chk("t6_vector", VECTOR, 0);
    chk("t6_vvalid", VEC_VALID, 0);
    chk("t6_spur", SPURIOUS, 0);
    tick();
    RST_N = 1'b1;
    tick(3);
    chk("t6_no_vvalid", VEC_VALID, 0);

    // Normal sequence after reset; EOI and AEOI clear in the same cycle.
    ir_pulse(8'h10);
    inta_pulse();
    chk("t7_isr4", ISR, 8'h10);
    push(8'hAC, 4, 0, 8'h10);
    inta_pulse();
    AEOI = 1'b1;
    ir_pulse(8'h04);
    chk("t7_int_ir2", INT, 1);
    inta_pulse();
    chk("t7_isr_nest", ISR, 8'h14);
    push(8'hAA, 2, 0, 8'h00);
    INTA = 1'b1;
    EOI_STB = 1'b1;
    EOI_SPECIFIC = 1'b1;
    EOI_LEVEL = 3'd4;
    tick();
    INTA = 1'b0;
    EOI_STB = 1'b0;
    EOI_SPECIFIC = 1'b0;
    tick();
    chk("t7_isr_both_clr", ISR, 8'h00);

    // AEOI on IR6, then IR6 and IR7 together.
    ICW2 = 8'h40;
    ir_pulse(8'h40);
    inta_pulse();
    chk("t5_isr6", ISR, 8'h40);
    push(8'h46, 6, 0, 8'h00);
    inta_pulse();
    chk("t5_aeoi_clr", ISR, 8'h00);
`ifdef PIC_ROTATE_EN
    w1 = 3'd7; w2 = 3'd6;
`else
    w1 = 3'd6; w2 = 3'd7;
`endif
    ir_pulse(8'hC0);
    chk("t5_irr67", IRR_OUT, 8'hC0);
    chk("t5_int", INT, 1);
    inta_pulse();
    chk("t5_first_win", INT_LEVEL, w1);
    push(8'h40 | 8'(w1), w1, 0, 8'h00);
    inta_pulse();
    tick();
    inta_pulse();
    chk("t5_second_win", INT_LEVEL, w2);
    push(8'h40 | 8'(w2), w2, 0, 8'h00);
    inta_pulse();
    tick(2);
    chk("t5_isr_end", ISR, 8'h00);
    chk("t5_irr_end", IRR_OUT, 8'h00);

    chk("sb_empty", sb_q.size(), 0);
    chk("vec_count", n_vec, n_push);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
